// File: rtl/johnson_phase_tracker.sv
// Validates and decodes a 4-bit Johnson counter stream into a phase index and a one-hot phase.
// A SEARCH/ACQUIRE/LOCKED machine tracks sequence integrity and counts faults.
module johnson_phase_tracker #(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2,
    parameter int ALLOW_HOLD = 1,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       jc_in,
    input  logic             jc_vld,
    input  logic             err_clr,
    output logic [2:0]       phase,
    output logic [7:0]       phase_oh,
    output logic             phase_vld,
    output logic             wrap,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    localparam logic [3:0] LOCK_CNT_C   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_CNT_C = 4'(UNLOCK_CNT);

    state_t           state_q, state_d;
    logic [2:0]       prev_q, prev_d;
    logic [3:0]       good_cnt_q, good_cnt_d;
    logic [3:0]       bad_cnt_q, bad_cnt_d;
    logic [2:0]       phase_q, phase_d;
    logic [7:0]       phase_oh_q, phase_oh_d;
    logic             phase_vld_q, phase_vld_d;
    logic             wrap_q, wrap_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic       dec_legal;
    logic [2:0] dec_phase;
    logic [7:0] dec_oh;
    logic [2:0] prev_inc;
    logic [3:0] good_inc;
    logic [3:0] bad_inc;
    logic       is_adv;
    logic       is_good;
    logic       is_wrap;

    always_comb begin
        dec_legal = 1'b1;
        dec_phase = 3'd0;
        case (jc_in)
            4'b0000: dec_phase = 3'd0;
            4'b1000: dec_phase = 3'd1;
            4'b1100: dec_phase = 3'd2;
            4'b1110: dec_phase = 3'd3;
            4'b1111: dec_phase = 3'd4;
            4'b0111: dec_phase = 3'd5;
            4'b0011: dec_phase = 3'd6;
            4'b0001: dec_phase = 3'd7;
            default: dec_legal = 1'b0;
        endcase
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_oh
        assign dec_oh[gi] = (dec_phase == 3'(gi));
    end

    assign prev_inc = prev_q + 3'd1;
    assign good_inc = good_cnt_q + 4'd1;
    assign bad_inc  = bad_cnt_q + 4'd1;
    assign is_adv   = dec_legal && (dec_phase == prev_inc);
    assign is_good  = is_adv || (dec_legal && (dec_phase == prev_q) && (ALLOW_HOLD != 0));
    assign is_wrap  = is_adv && (prev_q == 3'd7);

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        phase_d     = phase_q;
        phase_oh_d  = phase_oh_q;
        phase_vld_d = 1'b0;
        wrap_d      = 1'b0;
        err_d       = 1'b0;
        if (jc_vld) begin
            // Every legal sample updates the decode and the sequence reference.
            if (dec_legal) begin
                phase_d     = dec_phase;
                phase_oh_d  = dec_oh;
                phase_vld_d = 1'b1;
                prev_d      = dec_phase;
            end
            case (state_q)
                SEARCH: begin
                    if (dec_legal) begin
                        good_cnt_d = 4'd0;
                        state_d    = ACQUIRE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ACQUIRE: begin
                    if (!dec_legal) begin
                        err_d   = 1'b1;
                        state_d = SEARCH;
                    end else if (is_adv) begin
                        good_cnt_d = good_inc;
                        if (good_inc == LOCK_CNT_C) begin
                            state_d   = LOCKED;
                            bad_cnt_d = 4'd0;
                            wrap_d    = is_wrap;
                        end
                    end else if (!is_good) begin
                        err_d      = 1'b1;
                        good_cnt_d = 4'd0;
                    end
                end
                default: begin
                    if (is_good) begin
                        bad_cnt_d = 4'd0;
                        wrap_d    = is_wrap;
                    end else begin
                        err_d     = 1'b1;
                        bad_cnt_d = bad_inc;
                        if (bad_inc == UNLOCK_CNT_C) begin
                            state_d = SEARCH;
                        end
                    end
                end
            endcase
        end
        locked_d = (state_d == LOCKED);

        // A clear coinciding with a new error leaves that error counted.
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = err_d ? ERR_W'(1) : '0;
        end else if (err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEARCH;
            prev_q      <= 3'd0;
            good_cnt_q  <= 4'd0;
            bad_cnt_q   <= 4'd0;
            phase_q     <= 3'd0;
            phase_oh_q  <= 8'h00;
            phase_vld_q <= 1'b0;
            wrap_q      <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            phase_q     <= phase_d;
            phase_oh_q  <= phase_oh_d;
            phase_vld_q <= phase_vld_d;
            wrap_q      <= wrap_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign phase     = phase_q;
    assign phase_oh  = phase_oh_q;
    assign phase_vld = phase_vld_q;
    assign wrap      = wrap_q;
    assign locked    = locked_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_johnson_phase_tracker.sv
// Drives two tracker configurations (hold legal / hold illegal with 2-bit error counter)
// with directed and random Johnson streams and compares against a behavioural model.
module tb_johnson_phase_tracker;

    localparam int LC = 4;
    localparam int UC = 2;

    logic       clk = 1'b0;
    logic       rst, jc_vld, err_clr;
    logic [3:0] jc_in;

    logic [2:0] a_phase, b_phase;
    logic [7:0] a_phase_oh, b_phase_oh;
    logic       a_phase_vld, b_phase_vld, a_wrap, b_wrap;
    logic       a_locked, b_locked, a_err, b_err;
    logic [7:0] a_err_cnt;
    logic [1:0] b_err_cnt;

    int nvec = 0;
    int nbad = 0;

    always #5 clk = ~clk;

    johnson_phase_tracker #(.LOCK_CNT(LC), .UNLOCK_CNT(UC), .ALLOW_HOLD(1), .ERR_W(8)) dut_a (
        .clk(clk), .rst(rst), .jc_in(jc_in), .jc_vld(jc_vld), .err_clr(err_clr),
        .phase(a_phase), .phase_oh(a_phase_oh), .phase_vld(a_phase_vld), .wrap(a_wrap),
        .locked(a_locked), .err(a_err), .err_cnt(a_err_cnt));

    johnson_phase_tracker #(.LOCK_CNT(LC), .UNLOCK_CNT(UC), .ALLOW_HOLD(0), .ERR_W(2)) dut_b (
        .clk(clk), .rst(rst), .jc_in(jc_in), .jc_vld(jc_vld), .err_clr(err_clr),
        .phase(b_phase), .phase_oh(b_phase_oh), .phase_vld(b_phase_vld), .wrap(b_wrap),
        .locked(b_locked), .err(b_err), .err_cnt(b_err_cnt));

    // Behavioural model: one slot per configuration; state 0=search 1=acquire 2=locked.
    logic [3:0] codes [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                              4'b1111, 4'b0111, 4'b0011, 4'b0001};
    int ah   [2] = '{1, 0};
    int emax [2] = '{255, 3};
    int m_st[2], m_prev[2], m_g[2], m_b[2], m_ph[2], m_oh[2];
    int m_pv[2], m_wr[2], m_lk[2], m_er[2], m_ec[2];

    task automatic model(input int c);
        int p;
        bit leg, adv, good;
        if (rst) begin
            m_st[c] = 0; m_prev[c] = 0; m_g[c] = 0; m_b[c] = 0; m_ph[c] = 0; m_oh[c] = 0;
            m_pv[c] = 0; m_wr[c] = 0; m_lk[c] = 0; m_er[c] = 0; m_ec[c] = 0;
            return;
        end
        m_pv[c] = 0; m_wr[c] = 0; m_er[c] = 0;
        if (jc_vld) begin
            leg = 0; p = 0;
            for (int k = 0; k < 8; k++) if (codes[k] == jc_in) begin leg = 1; p = k; end
            adv  = leg && (p == (m_prev[c] + 1) % 8);
            good = adv || (leg && p == m_prev[c] && ah[c] == 1);
            if (m_st[c] == 0) begin
                if (leg) begin m_g[c] = 0; m_st[c] = 1; end
                else m_er[c] = 1;
            end else if (m_st[c] == 1) begin
                if (!leg) begin m_er[c] = 1; m_st[c] = 0; end
                else if (adv) begin
                    m_g[c]++;
                    if (m_g[c] == LC) begin m_st[c] = 2; m_b[c] = 0; m_wr[c] = (p == 0); end
                end else if (!good) begin m_er[c] = 1; m_g[c] = 0; end
            end else begin
                if (good) begin m_b[c] = 0; m_wr[c] = adv && (p == 0); end
                else begin
                    m_er[c] = 1; m_b[c]++;
                    if (m_b[c] == UC) m_st[c] = 0;
                end
            end
            if (leg) begin m_prev[c] = p; m_ph[c] = p; m_oh[c] = 1 << p; m_pv[c] = 1; end
        end
        m_lk[c] = (m_st[c] == 2);
        if (err_clr) m_ec[c] = m_er[c];
        else if (m_er[c] == 1 && m_ec[c] < emax[c]) m_ec[c]++;
    endtask

    function automatic logic [47:0] got_vec();
        return {1'b0, a_phase, a_phase_oh, a_phase_vld, a_wrap, a_locked, a_err, a_err_cnt,
                1'b0, b_phase, b_phase_oh, b_phase_vld, b_wrap, b_locked, b_err, 6'b0, b_err_cnt};
    endfunction

    function automatic logic [47:0] exp_vec();
        return {1'b0, 3'(m_ph[0]), 8'(m_oh[0]), 1'(m_pv[0]), 1'(m_wr[0]), 1'(m_lk[0]),
                1'(m_er[0]), 8'(m_ec[0]),
                1'b0, 3'(m_ph[1]), 8'(m_oh[1]), 1'(m_pv[1]), 1'(m_wr[1]), 1'(m_lk[1]),
                1'(m_er[1]), 8'(m_ec[1])};
    endfunction

    // One clock: apply inputs, let the edge happen, advance the model, settle.
    task automatic cyc(input logic r, input logic v, input logic [3:0] code, input logic clr);
        rst = r; jc_vld = v; jc_in = code; err_clr = clr;
        @(posedge clk);
        model(0);
        model(1);
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 0, 4'b0000, 0);
        cyc(1, 1, 4'b1000, 1);
        nvec++;
        if (got_vec() !== 48'h0) begin
            nbad++; $display("FAIL reset got %h want %h", got_vec(), 48'h0);
        end
        nvec++;
        if (got_vec() !== exp_vec()) begin
            nbad++; $display("FAIL reset_model got %h want %h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 9; i++) begin
            cyc(0, 1, codes[i % 8], 0);
            nvec++;
            if (got_vec() !== exp_vec()) begin
                nbad++; $display("FAIL sweep[%0d] got %h want %h", i, got_vec(), exp_vec());
            end
            nvec++;
            if ({a_phase, a_phase_vld, a_locked, a_wrap, a_err} !==
                {3'(i % 8), 1'b1, 1'(i >= 4), 1'(i == 8), 1'b0}) begin
                nbad++;
                $display("FAIL sweep_direct[%0d] got ph=%0d vld=%b lk=%b wr=%b er=%b",
                         i, a_phase, a_phase_vld, a_locked, a_wrap, a_err);
            end
        end
    endtask

    task automatic test_glitch();
        logic [3:0] seq [6] = '{4'b0101, 4'b1000, 4'b1100, 4'b0101, 4'b1010, 4'b1110};
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, seq[i], 0);
            nvec++;
            if (got_vec() !== exp_vec()) begin
                nbad++; $display("FAIL glitch[%0d] got %h want %h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_skip();
        logic [3:0] seq [7] = '{4'b1000, 4'b1100, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
        cyc(1, 0, 4'b0000, 0);
        for (int i = 0; i < 7; i++) begin
            cyc(0, 1, seq[i], 0);
            nvec++;
            if (got_vec() !== exp_vec()) begin
                nbad++; $display("FAIL skip[%0d] got %h want %h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_hold();
        logic [3:0] seq [4] = '{4'b1000, 4'b1100, 4'b1100, 4'b1100};
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, seq[i], 0);
            nvec++;
            if (got_vec() !== exp_vec()) begin
                nbad++; $display("FAIL hold[%0d] got %h want %h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_err_sat();
        cyc(1, 0, 4'b0000, 0);
        for (int i = 0; i < 7; i++) begin
            cyc(0, 1, 4'b0101 ^ 4'(i & 1), (i == 5) ? 1'b1 : 1'b0);
            if (i == 6) cyc(0, 0, 4'b0000, 1);
            nvec++;
            if (got_vec() !== exp_vec()) begin
                nbad++; $display("FAIL err_sat[%0d] got %h want %h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_vld_low();
        for (int i = 0; i < 6; i++) cyc(0, 1, codes[i], 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, (i & 1) ? 4'b1010 : 4'b0101, 0);
            nvec++;
            if (got_vec() !== exp_vec()) begin
                nbad++; $display("FAIL vld_low[%0d] got %h want %h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_rst_locked();
        for (int i = 6; i < 10; i++) cyc(0, 1, codes[i % 8], 0);
        cyc(1, 1, codes[2], 1);
        nvec++;
        if (got_vec() !== 48'h0) begin
            nbad++; $display("FAIL rst_locked got %h want %h", got_vec(), 48'h0);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, codes[(i + 5) % 8], 0);
            nvec++;
            if (got_vec() !== exp_vec()) begin
                nbad++; $display("FAIL after_rst[%0d] got %h want %h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] illeg [8] = '{4'b0010, 4'b0100, 4'b0101, 4'b0110,
                                  4'b1001, 4'b1010, 4'b1011, 4'b1101};
        int r;
        logic [3:0] code;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 65)      code = codes[(m_prev[0] + 1) % 8];
            else if (r < 77) code = codes[m_prev[0]];
            else if (r < 85) code = codes[(m_prev[0] + $urandom_range(2, 7)) % 8];
            else             code = illeg[$urandom_range(0, 7)];
            cyc(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 90) ? 1'b1 : 1'b0, code,
                ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
            nvec++;
            if (got_vec() !== exp_vec()) begin
                nbad++; $display("FAIL random[%0d] got %h want %h", i, got_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1; jc_vld = 1'b0; jc_in = 4'b0000; err_clr = 1'b0;
        test_reset();
        test_sweep();
        test_glitch();
        test_skip();
        test_hold();
        test_err_sat();
        test_vld_low();
        test_rst_locked();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
